// File: rtl/pkt_out_reader.sv
// pkt_out_reader: read side of the packet buffer.
// Accepts (pid, length) transmit requests, reads the stored beats of the slot
// out of packet memory, streams them downstream through a 4-entry output FIFO
// with ready/valid, and returns the pid to the allocator once the final beat
// has been accepted. Memory address is {pid, beat}; read data returns one
// cycle after the strobe.
module pkt_out_reader #(
    parameter int DATA_WIDTH = 512,
    parameter int CTRL_WIDTH = 8,
    parameter int PID_WIDTH  = 9,
    parameter int BEAT_BITS  = 5,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [PID_WIDTH-1:0]             req_pid,
    input  logic [LEN_WIDTH-1:0]             req_len,
    output logic                             mem_rd_en,
    output logic [PID_WIDTH+BEAT_BITS-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] mem_rd_data,
    output logic                             out_valid,
    input  logic                             out_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctl,
    output logic                             out_last,
    output logic                             pid_free_valid,
    output logic [PID_WIDTH-1:0]             pid_free
);

    // Beat counter is one bit wider than the beat index so a full slot
    // (2**BEAT_BITS beats) can be represented without wrapping to zero.
    localparam int CNT_WIDTH  = BEAT_BITS + 1;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_WIDTH  = 2;
    localparam int OCC_WIDTH  = 3;
    localparam logic [CNT_WIDTH-1:0] MAX_BEATS = CNT_WIDTH'(2 ** BEAT_BITS);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FREE
    } state_t;

    state_t                 state;
    logic [PID_WIDTH-1:0]   pid;
    logic [CNT_WIDTH-1:0]   len_eff;
    logic [CNT_WIDTH-1:0]   beat;
    logic [CNT_WIDTH-1:0]   len_clamped;

    // One read may be outstanding in the memory pipeline at any time.
    logic                   rd_inflight;
    logic                   rd_inflight_last;

    logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic [CTRL_WIDTH-1:0]  fifo_ctl  [FIFO_DEPTH];
    logic                   fifo_last [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [OCC_WIDTH-1:0]   fifo_occ;

    logic                   credit_ok;
    logic                   issue;
    logic                   last_issue;
    logic                   push;
    logic                   pop;

    // Requests longer than a slot are clamped to a full slot so the address
    // never crosses into the neighbouring pid.
    assign len_clamped = (req_len > LEN_WIDTH'(MAX_BEATS)) ? MAX_BEATS
                                                           : req_len[CNT_WIDTH-1:0];

    // A read is only issued when the FIFO is guaranteed room for it, counting
    // the read already travelling through memory.
    assign credit_ok  = (fifo_occ + OCC_WIDTH'(rd_inflight)) < OCC_WIDTH'(FIFO_DEPTH);
    assign issue      = (state == READ) && credit_ok;
    assign last_issue = issue && (beat == len_eff - CNT_WIDTH'(1));

    assign mem_rd_en   = issue;
    assign mem_rd_addr = {pid, beat[BEAT_BITS-1:0]};

    assign push      = rd_inflight;
    assign out_valid = (fifo_occ != '0);
    assign pop       = out_valid && out_rdy;

    assign out_data = fifo_data[rd_ptr];
    assign out_ctl  = fifo_ctl[rd_ptr];
    assign out_last = fifo_last[rd_ptr];

    // Request/transmit/free sequencing: IDLE -> READ -> DRAIN -> FREE -> IDLE.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            req_ready      <= 1'b0;
            pid            <= '0;
            len_eff        <= '0;
            beat           <= '0;
            pid_free_valid <= 1'b0;
            pid_free       <= '0;
        end else begin
            pid_free_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        pid       <= req_pid;
                        len_eff   <= len_clamped;
                        beat      <= '0;
                        req_ready <= 1'b0;
                        if (len_clamped == '0) begin
                            // Zero-length request: drop it and free the pid at once.
                            state          <= FREE;
                            pid_free_valid <= 1'b1;
                            pid_free       <= req_pid;
                        end else begin
                            state <= READ;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                READ: begin
                    if (issue) begin
                        beat <= beat + CNT_WIDTH'(1);
                        if (last_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state          <= FREE;
                        pid_free_valid <= 1'b1;
                        pid_free       <= pid;
                    end
                end
                FREE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    // Track the read in the memory pipeline and whether it carries the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
        end else begin
            rd_inflight      <= issue;
            rd_inflight_last <= last_issue;
        end
    end

    // Output FIFO: push returning read data, pop on downstream handshake.
    // NOTE: the small FIFO storage is reset so the beat outputs read as zero
    // during and right after reset; a large RAM would not be reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_occ <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_ctl[i]  <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_rd_data[DATA_WIDTH+CTRL_WIDTH-1:CTRL_WIDTH];
                fifo_ctl[wr_ptr]  <= mem_rd_data[CTRL_WIDTH-1:0];
                fifo_last[wr_ptr] <= rd_inflight_last;
                wr_ptr            <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            fifo_occ <= fifo_occ + OCC_WIDTH'(push) - OCC_WIDTH'(pop);
        end
    end

endmodule

// File: tb/tb_pkt_out_reader.sv
// tb_pkt_out_reader: self-checking bench for pkt_out_reader.
// A memory model returns an address-derived pattern one cycle after each read
// strobe. Every accepted request pushes its expected reads, beats and freed
// pid into scoreboard queues, which a negedge monitor pops as the DUT acts.
module tb_pkt_out_reader;

    localparam int DW = 512;
    localparam int CW = 8;
    localparam int PW = 9;
    localparam int BB = 5;
    localparam int LW = 8;
    localparam int AW = PW + BB;
    localparam int BW = 1 + DW + CW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [PW-1:0] req_pid = '0;
    logic [LW-1:0] req_len = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW+CW-1:0] mem_rd_data = '0;
    logic          out_valid;
    logic          out_rdy = 1'b1;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctl;
    logic          out_last;
    logic          pid_free_valid;
    logic [PW-1:0] pid_free;

    pkt_out_reader #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .PID_WIDTH(PW),
        .BEAT_BITS(BB), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pid(req_pid), .req_len(req_len),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_rdy(out_rdy),
        .out_data(out_data), .out_ctl(out_ctl), .out_last(out_last),
        .pid_free_valid(pid_free_valid), .pid_free(pid_free)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stored content of every {pid, beat} location.
    function automatic logic [DW+CW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {8'hA5, 3'b000, a, ~a[6:0]};
        return {{16{w}}, a[7:0] ^ 8'h3C};
    endfunction

    // Memory model: strobe and address captured away from the edge, data one cycle later.
    logic          rd_en_s = 1'b0;
    logic [AW-1:0] addr_s = '0;
    always @(negedge clk) begin
        rd_en_s <= mem_rd_en;
        addr_s  <= mem_rd_addr;
    end
    always @(posedge clk) begin
        if (rd_en_s) mem_rd_data <= mem_word(addr_s);
        else         mem_rd_data <= '1;
    end

    // Scoreboard queues and monitor state.
    logic [AW-1:0] sb_addr [$];
    logic [BW-1:0] sb_beat [$];
    logic [PW-1:0] sb_free [$];
    int            outstanding = 0;
    int            beats_seen = 0;
    int            rds_seen = 0;
    logic [AW-1:0] last_rd_addr = '0;
    bit            held = 1'b0;
    logic [BW-1:0] held_val = '0;
    int            m_len;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_exp;

    always @(negedge clk) begin
        if (reset) begin
            if (held) check("head_stable", {out_valid, out_last, out_data, out_ctl}, {1'b1, held_val});
            held     = out_valid && !out_rdy;
            held_val = {out_last, out_data, out_ctl};

            if (req_valid && req_ready) begin
                m_len = (int'(req_len) > 32) ? 32 : int'(req_len);
                for (int b = 0; b < m_len; b++) begin
                    m_addr = {req_pid, 5'(b)};
                    sb_addr.push_back(m_addr);
                    sb_beat.push_back({(b == m_len - 1), mem_word(m_addr)});
                end
                sb_free.push_back(req_pid);
            end

            if (mem_rd_en) begin
                rds_seen++;
                last_rd_addr = mem_rd_addr;
                check("credit", 32'(outstanding < 4), 32'd1);
                if (sb_addr.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    m_addr = sb_addr.pop_front();
                    check("rd_addr", mem_rd_addr, m_addr);
                end
            end

            if (out_valid && out_rdy) begin
                beats_seen++;
                if (sb_beat.size() == 0) check("beat_unexpected", 1, 0);
                else begin
                    m_exp = sb_beat.pop_front();
                    check("beat", {out_last, out_data, out_ctl}, m_exp);
                end
            end

            if (pid_free_valid) begin
                if (sb_free.size() == 0) check("free_unexpected", pid_free, 0);
                else check("pid_free", pid_free, sb_free.pop_front());
            end

            outstanding = outstanding + int'(mem_rd_en) - int'(out_valid && out_rdy);
        end
    end

    task automatic drive_rdy(input int mode, input int k);
        case (mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = k[0];
            default: out_rdy = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Issue one request (called just after a rising edge) and run it to its free pulse.
    task automatic send(input logic [PW-1:0] p, input logic [LW-1:0] l, input int mode, output bit ok);
        int  k;
        bit  acc;
        bit  freed;
        req_pid = p; req_len = l; req_valid = 1'b1;
        acc = 0; freed = 0; k = 0;
        while (!acc && k < 100) begin
            @(negedge clk);
            if (req_ready) acc = 1;
            @(posedge clk); #1;
            k++;
            drive_rdy(mode, k);
        end
        req_valid = 1'b0;
        while (acc && !freed && k < 2000) begin
            @(negedge clk);
            if (pid_free_valid) freed = 1;
            @(posedge clk); #1;
            k++;
            drive_rdy(mode, k);
        end
        out_rdy = 1'b1;
        ok = acc && freed;
    endtask

    typedef struct {
        logic [PW-1:0] pid;
        logic [LW-1:0] len;
        int            mode;
        int            exp_beats;
    } vec_t;

    vec_t vecs[8];
    bit   ok;
    int   t_free, t_acc;
    bit   sw, done;

    initial begin
        vecs[0] = '{9'd5,   8'd3,   0, 3};
        vecs[1] = '{9'd1,   8'd32,  1, 32};
        vecs[2] = '{9'd511, 8'd0,   0, 0};
        vecs[3] = '{9'd7,   8'd200, 0, 32};
        vecs[4] = '{9'd9,   8'd33,  2, 32};
        vecs[5] = '{9'd100, 8'd1,   0, 1};
        vecs[6] = '{9'd300, 8'd31,  2, 31};
        vecs[7] = '{9'd42,  8'd5,   1, 5};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {req_ready, mem_rd_en, out_valid, out_last, pid_free_valid, pid_free},
              '0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rst_ready_low", req_ready, 0);
        @(posedge clk); #1;
        check("rst_ready_rise", req_ready, 1);

        // Latency: pid=5 len=3 with out_rdy=1; handshake is cycle 0.
        req_valid = 1'b1; req_pid = 9'd5; req_len = 8'd3; out_rdy = 1'b1;
        @(negedge clk); check("lat_c0", {req_valid, req_ready}, 2'b11);
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk); check("lat_c1", {mem_rd_en, mem_rd_addr, out_valid}, {1'b1, 14'h0A0, 1'b0});
        @(negedge clk); check("lat_c2", {mem_rd_en, mem_rd_addr, out_valid}, {1'b1, 14'h0A1, 1'b0});
        @(negedge clk); check("lat_c3", {mem_rd_en, mem_rd_addr, out_valid, out_last}, {1'b1, 14'h0A2, 2'b10});
        @(negedge clk); check("lat_c4", {mem_rd_en, out_valid, out_last}, 3'b010);
        @(negedge clk); check("lat_c5", {out_valid, out_last, pid_free_valid}, 3'b110);
        @(negedge clk); check("lat_c6", {out_valid, pid_free_valid, pid_free, req_ready}, {2'b01, 9'd5, 1'b0});
        @(negedge clk); check("lat_c7", {pid_free_valid, req_ready}, 2'b01);
        @(posedge clk); #1;

        // Table-driven requests.
        for (int i = 0; i < 8; i++) begin
            beats_seen = 0;
            rds_seen   = 0;
            send(vecs[i].pid, vecs[i].len, vecs[i].mode, ok);
            check("vec_done", ok, 1);
            check("vec_beats", beats_seen, vecs[i].exp_beats);
            check("vec_reads", rds_seen, vecs[i].exp_beats);
            if (vecs[i].exp_beats > 0)
                check("vec_last_addr", last_rd_addr, {vecs[i].pid, 5'(vecs[i].exp_beats - 1)});
        end

        // Reset in the middle of a 20-beat packet, after 10 beats went out.
        beats_seen = 0;
        req_valid = 1'b1; req_pid = 9'd6; req_len = 8'd20;
        @(negedge clk);
        @(posedge clk); #1; req_valid = 1'b0;
        for (int k = 0; k < 100 && beats_seen < 10; k++) @(negedge clk);
        check("rst_mid_reach", beats_seen, 10);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("rst_mid_out", {req_ready, mem_rd_en, out_valid, out_last, pid_free_valid, pid_free, out_ctl},
              '0);
        check("rst_mid_data", out_data, '0);
        sb_addr.delete(); sb_beat.delete(); sb_free.delete();
        outstanding = 0; held = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_ready_low", req_ready, 0);
        @(posedge clk); #1;
        check("rst_mid_ready", req_ready, 1);
        beats_seen = 0;
        send(9'd2, 8'd1, 0, ok);
        check("post_rst_done", ok, 1);
        check("post_rst_beats", beats_seen, 1);

        // req_valid held high across two requests.
        beats_seen = 0;
        req_valid = 1'b1; req_pid = 9'd3; req_len = 8'd2;
        t_free = -100; t_acc = -1; sw = 0; done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (req_valid && req_ready && req_pid == 9'd3) sw = 1;
            if (req_valid && req_ready && req_pid == 9'd4) t_acc = cyc;
            if (pid_free_valid && pid_free == 9'd3) t_free = cyc;
            if (pid_free_valid && pid_free == 9'd4) done = 1;
            @(posedge clk); #1;
            if (sw) begin req_pid = 9'd4; req_len = 8'd1; sw = 0; end
            if (t_acc >= 0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("b2b_done", done, 1);
        check("b2b_gap", t_acc - t_free, 1);
        check("b2b_beats", beats_seen, 3);

        repeat (4) @(posedge clk);
        #1;
        check("sb_addr_empty", sb_addr.size(), 0);
        check("sb_beat_empty", sb_beat.size(), 0);
        check("sb_free_empty", sb_free.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
